// File: rtl/dir_key_encoder.sv
// Four-button direction encoder: per-button synchroniser and debouncer, press-edge
// detection, priority select with optional reversal blocking, and a held direction code.
module dir_key_encoder #(
    parameter int DEBOUNCE_CYCLES = 1000000,
    parameter bit BLOCK_REVERSE   = 1'b1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       button_up,
    input  logic       button_down,
    input  logic       button_left,
    input  logic       button_right,
    output logic [2:0] way,
    output logic       dir_valid
);

    localparam int CW = $clog2(DEBOUNCE_CYCLES) + 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

    localparam logic [2:0] WAY_NONE  = 3'b000;
    localparam logic [2:0] WAY_UP    = 3'b001;
    localparam logic [2:0] WAY_DOWN  = 3'b011;
    localparam logic [2:0] WAY_LEFT  = 3'b010;
    localparam logic [2:0] WAY_RIGHT = 3'b110;

    logic [3:0]    raw;
    logic [3:0]    sync1;
    logic [3:0]    sync2;
    logic [3:0]    level;
    logic [3:0]    level_d;
    logic [CW-1:0] cnt [4];

    logic [3:0] press;
    logic       sel_valid;
    logic [2:0] sel_code;
    logic [2:0] opposite;
    logic       accept;

    // Bit order sets press priority: index 0 wins.
    assign raw = {button_right, button_left, button_down, button_up};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1   <= '0;
            sync2   <= '0;
            level   <= '0;
            level_d <= '0;
            for (int i = 0; i < 4; i++) begin
                cnt[i] <= '0;
            end
        end else begin
            sync1   <= raw;
            sync2   <= sync1;
            level_d <= level;
            for (int i = 0; i < 4; i++) begin
                if (sync2[i] == level[i]) begin
                    cnt[i] <= '0;
                end else if (cnt[i] == CNT_LAST) begin
                    level[i] <= ~level[i];
                    cnt[i]   <= '0;
                end else begin
                    cnt[i] <= cnt[i] + 1'b1;
                end
            end
        end
    end

    always_comb begin
        press     = level & ~level_d;
        sel_valid = 1'b1;
        sel_code  = WAY_NONE;
        if (press[0])      sel_code = WAY_UP;
        else if (press[1]) sel_code = WAY_DOWN;
        else if (press[2]) sel_code = WAY_LEFT;
        else if (press[3]) sel_code = WAY_RIGHT;
        else               sel_valid = 1'b0;

        case (way)
            WAY_UP:    opposite = WAY_DOWN;
            WAY_DOWN:  opposite = WAY_UP;
            WAY_LEFT:  opposite = WAY_RIGHT;
            WAY_RIGHT: opposite = WAY_LEFT;
            default:   opposite = WAY_NONE;
        endcase

        // A rejected reversal still consumes the edge, so lower-priority presses stay masked.
        accept = sel_valid && !(BLOCK_REVERSE && (sel_code == opposite));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            way       <= WAY_NONE;
            dir_valid <= 1'b0;
        end else begin
            dir_valid <= accept;
            if (accept) begin
                way <= sel_code;
            end
        end
    end

endmodule

// File: tb/tb_dir_key_encoder.sv
// Bench for dir_key_encoder: two instances (reversal blocking on/off) share the buttons;
// pulses are collected by a monitor and matched against expected pulses per scenario.
module tb_dir_key_encoder;

    localparam int D = 4;
    localparam int LAT = D + 3;

    typedef struct {
        int         inst;
        int         cyc;
        logic [2:0] way;
    } ev_t;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       b_up = 1'b0, b_down = 1'b0, b_left = 1'b0, b_right = 1'b0;
    logic [2:0] way0, way1;
    logic       dv0, dv1;

    int  cyc = 0;
    int  n_assert = 0;
    int  n_fail = 0;
    ev_t exp_q[$];
    ev_t obs_q[$];
    ev_t e, o;

    dir_key_encoder #(.DEBOUNCE_CYCLES(D), .BLOCK_REVERSE(1'b1)) dut0 (
        .clk(clk), .rst_n(rst_n),
        .button_up(b_up), .button_down(b_down), .button_left(b_left), .button_right(b_right),
        .way(way0), .dir_valid(dv0)
    );

    dir_key_encoder #(.DEBOUNCE_CYCLES(D), .BLOCK_REVERSE(1'b0)) dut1 (
        .clk(clk), .rst_n(rst_n),
        .button_up(b_up), .button_down(b_down), .button_left(b_left), .button_right(b_right),
        .way(way1), .dir_valid(dv1)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (dv0) obs_q.push_back('{0, cyc, way0});
        if (dv1) obs_q.push_back('{1, cyc, way1});
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached, expected end of test");
        $fatal(1);
    end

    task automatic wait_neg(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic expect_both(input int c, input logic [2:0] w0, input logic [2:0] w1);
        exp_q.push_back('{0, c, w0});
        exp_q.push_back('{1, c, w1});
    endtask

    task automatic test_reset;
        @(negedge clk);
        rst_n = 1'b0;
        for (int i = 0; i < 5; i++) begin
            if (i == 3) rst_n = 1'b1;
            @(negedge clk);
            n_assert++;
            if (way0 !== 3'b000 || dv0 !== 1'b0 || way1 !== 3'b000 || dv1 !== 1'b0) begin
                n_fail++;
                $display("FAIL reset step %0d: way0=%b dv0=%b way1=%b dv1=%b, required 000/0", i, way0, dv0, way1, dv1);
            end
        end
        obs_q.delete();
    endtask

    task automatic test_single_press;
        b_up = 1'b1;
        expect_both(cyc + LAT, 3'b001, 3'b001);
        wait_neg(50);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            n_assert++;
            if (obs_q.size() == 0) begin
                n_fail++;
                $display("FAIL single_press inst %0d: no pulse, required way %b at cycle %0d", e.inst, e.way, e.cyc);
            end else begin
                o = obs_q.pop_front();
                if (o.inst !== e.inst || o.cyc !== e.cyc || o.way !== e.way) begin
                    n_fail++;
                    $display("FAIL single_press: got inst %0d way %b cycle %0d, required inst %0d way %b cycle %0d", o.inst, o.way, o.cyc, e.inst, e.way, e.cyc);
                end
            end
        end
        n_assert++;
        if (obs_q.size() != 0 || way0 !== 3'b001) begin
            n_fail++;
            $display("FAIL single_press hold: extra pulses %0d way0 %b, required 0 and 001", obs_q.size(), way0);
        end
        obs_q.delete();
        b_up = 1'b0;
        wait_neg(10);
    endtask

    task automatic test_bounce;
        for (int i = 0; i < 10; i++) begin
            b_left = ~b_left;
            wait_neg(2);
        end
        n_assert++;
        if (obs_q.size() != 0 || way0 !== 3'b001 || way1 !== 3'b001) begin
            n_fail++;
            $display("FAIL bounce toggling: pulses %0d way0 %b way1 %b, required 0 001 001", obs_q.size(), way0, way1);
        end
        b_left = 1'b1;
        expect_both(cyc + LAT, 3'b010, 3'b010);
        wait_neg(12);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            n_assert++;
            if (obs_q.size() == 0) begin
                n_fail++;
                $display("FAIL bounce inst %0d: no pulse, required way %b at cycle %0d", e.inst, e.way, e.cyc);
            end else begin
                o = obs_q.pop_front();
                if (o.inst !== e.inst || o.cyc !== e.cyc || o.way !== e.way) begin
                    n_fail++;
                    $display("FAIL bounce: got inst %0d way %b cycle %0d, required inst %0d way %b cycle %0d", o.inst, o.way, o.cyc, e.inst, e.way, e.cyc);
                end
            end
        end
        n_assert++;
        if (obs_q.size() != 0) begin
            n_fail++;
            $display("FAIL bounce extra: %0d unexpected pulses, required 0", obs_q.size());
        end
        obs_q.delete();
        b_left = 1'b0;
        wait_neg(10);
    endtask

    task automatic test_reversal;
        b_up = 1'b1;
        expect_both(cyc + LAT, 3'b001, 3'b001);
        wait_neg(10);
        b_up = 1'b0;
        wait_neg(10);
        b_down = 1'b1;
        exp_q.push_back('{1, cyc + LAT, 3'b011});
        wait_neg(10);
        n_assert++;
        if (way0 !== 3'b001 || way1 !== 3'b011) begin
            n_fail++;
            $display("FAIL reversal down: way0 %b way1 %b, required 001 011", way0, way1);
        end
        b_down = 1'b0;
        wait_neg(10);
        b_right = 1'b1;
        expect_both(cyc + LAT, 3'b110, 3'b110);
        wait_neg(10);
        b_right = 1'b0;
        wait_neg(10);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            n_assert++;
            if (obs_q.size() == 0) begin
                n_fail++;
                $display("FAIL reversal inst %0d: no pulse, required way %b at cycle %0d", e.inst, e.way, e.cyc);
            end else begin
                o = obs_q.pop_front();
                if (o.inst !== e.inst || o.cyc !== e.cyc || o.way !== e.way) begin
                    n_fail++;
                    $display("FAIL reversal: got inst %0d way %b cycle %0d, required inst %0d way %b cycle %0d", o.inst, o.way, o.cyc, e.inst, e.way, e.cyc);
                end
            end
        end
        n_assert++;
        if (obs_q.size() != 0 || way0 !== 3'b110 || way1 !== 3'b110) begin
            n_fail++;
            $display("FAIL reversal end: extra %0d way0 %b way1 %b, required 0 110 110", obs_q.size(), way0, way1);
        end
        obs_q.delete();
    endtask

    task automatic test_simultaneous;
        rst_n = 1'b0;
        wait_neg(2);
        rst_n = 1'b1;
        wait_neg(2);
        b_left  = 1'b1;
        b_right = 1'b1;
        expect_both(cyc + LAT, 3'b010, 3'b010);
        wait_neg(30);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            n_assert++;
            if (obs_q.size() == 0) begin
                n_fail++;
                $display("FAIL simultaneous inst %0d: no pulse, required way %b at cycle %0d", e.inst, e.way, e.cyc);
            end else begin
                o = obs_q.pop_front();
                if (o.inst !== e.inst || o.cyc !== e.cyc || o.way !== e.way) begin
                    n_fail++;
                    $display("FAIL simultaneous: got inst %0d way %b cycle %0d, required inst %0d way %b cycle %0d", o.inst, o.way, o.cyc, e.inst, e.way, e.cyc);
                end
            end
        end
        n_assert++;
        if (obs_q.size() != 0 || way0 !== 3'b010 || way1 !== 3'b010) begin
            n_fail++;
            $display("FAIL simultaneous end: extra %0d way0 %b way1 %b, required 0 010 010", obs_q.size(), way0, way1);
        end
        obs_q.delete();
        b_left  = 1'b0;
        b_right = 1'b0;
        wait_neg(10);
    endtask

    task automatic test_same_dir;
        b_up = 1'b1;
        expect_both(cyc + LAT, 3'b001, 3'b001);
        wait_neg(10);
        b_up = 1'b0;
        wait_neg(10);
        b_right = 1'b1;
        expect_both(cyc + LAT, 3'b110, 3'b110);
        wait_neg(10);
        b_right = 1'b0;
        wait_neg(10);
        b_right = 1'b1;
        expect_both(cyc + LAT, 3'b110, 3'b110);
        wait_neg(20);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            n_assert++;
            if (obs_q.size() == 0) begin
                n_fail++;
                $display("FAIL same_dir inst %0d: no pulse, required way %b at cycle %0d", e.inst, e.way, e.cyc);
            end else begin
                o = obs_q.pop_front();
                if (o.inst !== e.inst || o.cyc !== e.cyc || o.way !== e.way) begin
                    n_fail++;
                    $display("FAIL same_dir: got inst %0d way %b cycle %0d, required inst %0d way %b cycle %0d", o.inst, o.way, o.cyc, e.inst, e.way, e.cyc);
                end
            end
        end
        n_assert++;
        if (obs_q.size() != 0 || way0 !== 3'b110) begin
            n_fail++;
            $display("FAIL same_dir end: extra %0d way0 %b, required 0 110", obs_q.size(), way0);
        end
        obs_q.delete();
        b_right = 1'b0;
        wait_neg(10);
    endtask

    task automatic test_reset_mid_hold;
        b_down = 1'b1;
        wait_neg(5);
        rst_n = 1'b0;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            n_assert++;
            if (way0 !== 3'b000 || way1 !== 3'b000 || dv0 !== 1'b0) begin
                n_fail++;
                $display("FAIL reset_mid_hold in reset: way0 %b way1 %b dv0 %b, required 000 000 0", way0, way1, dv0);
            end
        end
        rst_n = 1'b1;
        expect_both(cyc + LAT, 3'b011, 3'b011);
        wait_neg(12);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            n_assert++;
            if (obs_q.size() == 0) begin
                n_fail++;
                $display("FAIL reset_mid_hold inst %0d: no pulse, required way %b at cycle %0d", e.inst, e.way, e.cyc);
            end else begin
                o = obs_q.pop_front();
                if (o.inst !== e.inst || o.cyc !== e.cyc || o.way !== e.way) begin
                    n_fail++;
                    $display("FAIL reset_mid_hold: got inst %0d way %b cycle %0d, required inst %0d way %b cycle %0d", o.inst, o.way, o.cyc, e.inst, e.way, e.cyc);
                end
            end
        end
        n_assert++;
        if (obs_q.size() != 0) begin
            n_fail++;
            $display("FAIL reset_mid_hold extra: %0d unexpected pulses, required 0", obs_q.size());
        end
        obs_q.delete();
        b_down = 1'b0;
        wait_neg(10);
    endtask

    initial begin
        test_reset();
        test_single_press();
        test_bounce();
        test_reversal();
        test_simultaneous();
        test_same_dir();
        test_reset_mid_hold();
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/dir_key_encoder.md
# dir_key_encoder

Turns four raw push-buttons into one registered 3-bit direction code, `way`, for the direction-decode stage. Each button input is synchronised and debounced. Each clean press is edge-detected. Simultaneous presses are resolved by priority, and direct reversals are optionally rejected. The last accepted direction is held until a new one is accepted.

## Interface
- `DEBOUNCE_CYCLES`, default 1000000: consecutive clock edges a synchronised input must disagree with its debounced level before that level flips (10 ms at 100 MHz). Legal values are 2 or more.
- `BLOCK_REVERSE`, default 1: when 1, a press for the direction opposite to the current `way` is ignored.
- `clk` in, 1 bit: single clock. All state is on the rising edge.
- `rst_n` in, 1 bit: asynchronous, active-low reset.
- `button_up` in, 1 bit: raw, active-high, asynchronous to `clk`, may bounce.
- `button_down` in, 1 bit: same as `button_up`.
- `button_left` in, 1 bit: same as `button_up`.
- `button_right` in, 1 bit: same as `button_up`.
- `way` out, 3 bits: registered direction code. Up = 3'b001, down = 3'b011, left = 3'b010, right = 3'b110, none = 3'b000.
- `dir_valid` out, 1 bit: registered. Pulses high for one cycle on the same edge that an accepted press updates `way`.

## Operation
- Reset values: `way` = 3'b000, `dir_valid` = 0, both synchroniser stages = 0, debounced levels = 0, debounce counters = 0.
- Per-button path: two-flop synchroniser, then a debounce counter, then a debounced level.
  - Counter width is $clog2(DEBOUNCE_CYCLES)+1.
  - On each edge where the synchronised sample equals the debounced level, the counter clears to 0.
  - Otherwise the counter increments. On the DEBOUNCE_CYCLES-th consecutive disagreeing edge, the debounced level flips and the counter clears.
  - The counter never wraps. Any agreeing sample restarts the count.
- A press event is a 0→1 transition of a debounced level. Releases (1→0) generate no event.
- If several press events occur on the same edge, priority is up > down > left > right. Only the highest-priority event is considered; the others are discarded.
- Acceptance of the selected press:
  - If `BLOCK_REVERSE` = 1 and the press is the opposite of the current `way` (up↔down, left↔right), it is rejected: `way` is unchanged and `dir_valid` stays 0.
  - A rejected higher-priority press still masks lower-priority presses on that edge.
  - Otherwise the press is accepted: `way` takes the new code and `dir_valid` = 1 for one cycle.
  - Re-pressing the current direction is accepted: `way` is unchanged and `dir_valid` pulses.
  - When `way` = 3'b000, every direction is accepted.
- Holding a button gives exactly one event. The button must debounce low, then high again, to produce another.
- `way` never takes any value other than the five listed codes.
- Reset asserted mid-debounce or mid-hold clears all state immediately. A button still held when reset is released is debounced afresh and produces one press event.

## Timing
- Press latency: if a raw input goes high and stays stable before clock edge 1, then:
  - sync stage 1 samples high at edge 1, and sync stage 2 at edge 2;
  - the counter disagrees on edges 3 … DEBOUNCE_CYCLES+2;
  - the debounced level rises at edge DEBOUNCE_CYCLES+2;
  - `way` and `dir_valid` update at edge DEBOUNCE_CYCLES+3.
- Release latency: the debounced level falls DEBOUNCE_CYCLES+2 edges after a stable low. No output change results.
- `dir_valid` is high for exactly one cycle per accepted press. The minimum spacing between pulses from one button is 2·DEBOUNCE_CYCLES edges.
- Bounce: any glitch shorter than DEBOUNCE_CYCLES cycles, measured at sync stage 2, causes no level change.
- There is no combinational path from any input to any output.

## Test plan
All scenarios use DEBOUNCE_CYCLES = 4.
- Reset then single press:
  - `rst_n` low for 3 cycles, then release. `way` = 000 and `dir_valid` = 0 during and after reset.
  - Stable `button_up` high → `way` = 001 with a single `dir_valid` pulse exactly 7 edges later. Holding the button for 50 cycles gives no further pulse.
- Bounce rejection: `button_left` toggles every 2 cycles for 20 cycles, then holds high. No `way` change during toggling; `way` = 010 seven edges after the final rise.
- Reversal blocking (`BLOCK_REVERSE` = 1):
  - From `way` = 001, pressing down leaves `way` = 001 with no pulse.
  - Then pressing right gives `way` = 110 with a pulse.
  - Repeat with `BLOCK_REVERSE` = 0: pressing down gives `way` = 011 with a pulse.
- Simultaneous press: from `way` = 000, left and right rise on the same cycle. Result is `way` = 010 and exactly one pulse; right is not applied later.
- Same direction: from `way` = 110, release and re-press right. `way` stays 110 and `dir_valid` pulses once.
- Reset mid-hold: `button_down` held, `rst_n` pulsed low at cycle 3 of debounce, button kept held. `way` = 000 during reset; after release, `way` = 011 seven edges after `rst_n` rises.
